// File: rtl/sdes_decrypt_seq.sv
// sdes_decrypt_seq: multi-cycle S-DES decryption engine.
// Accepts ciphertext + 10-bit key on a valid/ready handshake, derives K1/K2,
// runs the two Feistel rounds in reverse key order (K2 then K1) and presents
// the plaintext on a second valid/ready handshake. Fixed 4-cycle latency.
module sdes_decrypt_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] key10,
  input  logic [7:0] ct_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] pt_out,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KEY  = 3'd1,
    RND1 = 3'd2,
    RND2 = 3'd3,
    FIN  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state_reg;
  state_t     state_next;

  logic [9:0] key_reg;
  logic [7:0] ct_reg;
  logic [7:0] k1_reg;
  logic [7:0] k2_reg;
  logic [7:0] data_reg;
  logic [7:0] pt_reg;
  logic       out_valid_reg;

  // Positions are 1-based with 1 = MSB, so position p of an n-bit word is bit n-p.

  function automatic logic [9:0] p10(input logic [9:0] k);
    p10 = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  // P8 only draws on positions 3..10, so it takes the low 8 bits of the 10-bit word.
  function automatic logic [7:0] p8(input logic [7:0] k);
    p8 = {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] x);
    ip = {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    ip_inv = {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] r);
    ep = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] s);
    p4 = {s[2], s[0], s[1], s[3]};
  endfunction

  // S-box index = {row, col} with row = bits 1,4 and col = bits 2,3.
  function automatic logic [1:0] s0(input logic [3:0] x);
    logic [1:0] v;
    v = 2'd0;
    case ({x[3], x[0], x[2], x[1]})
      4'd0:  v = 2'd1;
      4'd1:  v = 2'd0;
      4'd2:  v = 2'd3;
      4'd3:  v = 2'd2;
      4'd4:  v = 2'd3;
      4'd5:  v = 2'd2;
      4'd6:  v = 2'd1;
      4'd7:  v = 2'd0;
      4'd8:  v = 2'd0;
      4'd9:  v = 2'd2;
      4'd10: v = 2'd1;
      4'd11: v = 2'd3;
      4'd12: v = 2'd3;
      4'd13: v = 2'd1;
      4'd14: v = 2'd3;
      default: v = 2'd2;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] s1(input logic [3:0] x);
    logic [1:0] v;
    v = 2'd0;
    case ({x[3], x[0], x[2], x[1]})
      4'd0:  v = 2'd0;
      4'd1:  v = 2'd1;
      4'd2:  v = 2'd2;
      4'd3:  v = 2'd3;
      4'd4:  v = 2'd2;
      4'd5:  v = 2'd0;
      4'd6:  v = 2'd1;
      4'd7:  v = 2'd3;
      4'd8:  v = 2'd3;
      4'd9:  v = 2'd0;
      4'd10: v = 2'd1;
      4'd11: v = 2'd0;
      4'd12: v = 2'd2;
      4'd13: v = 2'd1;
      4'd14: v = 2'd0;
      default: v = 2'd3;
    endcase
    return v;
  endfunction

  // One Feistel round: left half mixed with F(right, subkey), right passes through.
  function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] k);
    logic [7:0] e;
    logic [3:0] s;
    e = ep(d[3:0]) ^ k;
    s = {s0(e[7:4]), s1(e[3:0])};
    return {d[7:4] ^ p4(s), d[3:0]};
  endfunction

  function automatic logic [7:0] sw(input logic [7:0] d);
    sw = {d[3:0], d[7:4]};
  endfunction

  // Key schedule from the latched key: LS1 per half for K1, two more rotations for K2.
  logic [9:0] p10_key;
  logic [9:0] ls1_key;
  logic [9:0] ls3_key;
  logic [7:0] k1_calc;
  logic [7:0] k2_calc;

  assign p10_key = p10(key_reg);
  assign ls1_key = {p10_key[8:5], p10_key[9], p10_key[3:0], p10_key[4]};
  assign ls3_key = {ls1_key[7:5], ls1_key[9:8], ls1_key[2:0], ls1_key[4:3]};
  assign k1_calc = p8(ls1_key[7:0]);
  assign k2_calc = p8(ls3_key[7:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: one step per cycle, waits only in IDLE and DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = KEY;
      KEY:     state_next = RND1;
      RND1:    state_next = RND2;
      RND2:    state_next = FIN;
      FIN:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch inputs, build subkeys, run rounds, publish and hold the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg       <= 10'd0;
      ct_reg        <= 8'd0;
      k1_reg        <= 8'd0;
      k2_reg        <= 8'd0;
      data_reg      <= 8'd0;
      pt_reg        <= 8'd0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            key_reg <= key10;
            ct_reg  <= ct_in;
          end
        end
        KEY: begin
          k1_reg   <= k1_calc;
          k2_reg   <= k2_calc;
          data_reg <= ip(ct_reg);
        end
        RND1: data_reg <= fk(data_reg, k2_reg);
        RND2: data_reg <= fk(sw(data_reg), k1_reg);
        FIN: begin
          pt_reg        <= ip_inv(data_reg);
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !reset;
  assign pt_out    = pt_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_sdes_decrypt_seq.sv
// Directed bench for sdes_decrypt_seq: reset, known vector, backpressure,
// input isolation, back-to-back, mid-operation reset and an encrypt/decrypt
// round-trip sweep driven by an independent table-based S-DES encryptor.
module tb_sdes_decrypt_seq;

  logic       clk;
  logic       reset;
  logic [9:0] key10;
  logic [7:0] ct_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] pt_out;
  logic       out_valid;
  logic       out_ready;

  int checks;
  int failures;

  localparam logic [9:0] KEY_A = 10'b1010000010;

  // Permutation tables as hex digits of 1-based positions (A = 10), first entry in the top digit.
  localparam logic [39:0] T_P10   = 40'h35274A1986;
  localparam logic [39:0] T_P8    = 40'h00637485A9;
  localparam logic [39:0] T_IP    = 40'h0026314857;
  localparam logic [39:0] T_IPINV = 40'h0041357286;
  localparam logic [39:0] T_EP    = 40'h0041232341;
  localparam logic [39:0] T_P4    = 40'h0000002431;
  // S-boxes as 16 two-bit entries, index row*4+col, entry 0 in the top bits.
  localparam logic [31:0] T_S0    = 32'h4EE427DE;
  localparam logic [31:0] T_S1    = 32'h1B87C493;

  sdes_decrypt_seq dut (
    .clk       (clk),
    .reset     (reset),
    .key10     (key10),
    .ct_in     (ct_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_out    (pt_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference S-DES encryptor ----------------
  function automatic logic [9:0] permute(input logic [9:0] x, input int n_in, input int n_out,
                                         input logic [39:0] tbl);
    logic [9:0] r;
    int pos;
    r = '0;
    for (int i = 0; i < n_out; i++) begin
      pos = int'(tbl[4*(n_out-1-i) +: 4]);
      r[n_out-1-i] = x[n_in-pos];
    end
    return r;
  endfunction

  function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] x);
    int idx;
    idx = {x[3], x[0]} * 4 + {x[2], x[1]};
    return tbl[2*(15-idx) +: 2];
  endfunction

  function automatic logic [7:0] model_fk(input logic [7:0] d, input logic [7:0] k);
    logic [9:0] e;
    logic [9:0] p;
    logic [3:0] s;
    e = permute({6'b0, d[3:0]}, 4, 8, T_EP);
    e[7:0] = e[7:0] ^ k;
    s = {sbox(T_S0, e[7:4]), sbox(T_S1, e[3:0])};
    p = permute({6'b0, s}, 4, 4, T_P4);
    return {d[7:4] ^ p[3:0], d[3:0]};
  endfunction

  function automatic logic [7:0] model_encrypt(input logic [9:0] key, input logic [7:0] pt);
    logic [9:0] p, ls1, ls3, k1w, k2w, d;
    p   = permute(key, 10, 10, T_P10);
    ls1 = {p[8:5], p[9], p[3:0], p[4]};
    ls3 = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
    k1w = permute(ls1, 10, 8, T_P8);
    k2w = permute(ls3, 10, 8, T_P8);
    d   = permute({2'b0, pt}, 8, 8, T_IP);
    d[7:0] = model_fk(d[7:0], k1w[7:0]);
    d[7:0] = {d[3:0], d[7:4]};
    d[7:0] = model_fk(d[7:0], k2w[7:0]);
    d   = permute({2'b0, d[7:0]}, 8, 8, T_IPINV);
    return d[7:0];
  endfunction

  // ---------------- handshake helpers ----------------
  // Presents a block and returns at accept-edge + 1.
  task automatic accept(input logic [9:0] k, input logic [7:0] c);
    int guard;
    key10 = k;
    ct_in = c;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from accept+1 until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++;
    if (pt_out !== 8'h00) begin failures++; $display("FAIL reset_pt_out: got %h required 00", pt_out); end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %0b required 1", in_ready); end
    $display("test_reset: in_ready=%0b out_valid=%0b pt_out=%h", in_ready, out_valid, pt_out);
  endtask

  task automatic test_known_vector;
    int lat;
    out_ready = 1'b1;
    accept(KEY_A, 8'b00111000);
    wait_valid(lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL known_latency: got %0d required 4", lat); end
    checks++;
    if (pt_out !== 8'b10010111) begin failures++; $display("FAIL known_pt: got %b required 10010111", pt_out); end
    checks++;
    if (dut.k1_reg !== 8'b10100100) begin failures++; $display("FAIL known_k1: got %b required 10100100", dut.k1_reg); end
    checks++;
    if (dut.k2_reg !== 8'b01000011) begin failures++; $display("FAIL known_k2: got %b required 01000011", dut.k2_reg); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL known_drain: out_valid=%0b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL known_idle: in_ready=%0b required 1", in_ready); end
    $display("test_known_vector: ct=38 pt=%h latency=%0d", pt_out, lat);
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    accept(KEY_A, 8'b00111000);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || pt_out !== 8'h97 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%0b pt=%h in_ready=%0b required 1/97/0",
                 i, out_valid, pt_out, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (pt_out !== 8'h97) begin failures++; $display("FAIL bp_pt_hold: got %h required 97", pt_out); end
    $display("test_backpressure: held 10 cycles, pt=%h", pt_out);
  endtask

  task automatic test_input_isolation;
    int lat;
    int outs;
    out_ready = 1'b1;
    accept(KEY_A, 8'b00111000);
    lat = 0;
    while (!out_valid && lat < 20) begin
      key10 = 10'($urandom);
      ct_in = 8'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat != 4) begin failures++; $display("FAIL iso_latency: got %0d required 4", lat); end
    checks++;
    if (pt_out !== 8'h97) begin failures++; $display("FAIL iso_pt: got %h required 97", pt_out); end
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) outs++;
    end
    checks++;
    if (outs != 0) begin failures++; $display("FAIL iso_single_output: extra valid cycles %0d required 0", outs); end
    $display("test_input_isolation: pt=%h latency=%0d", pt_out, lat);
  endtask

  task automatic test_back_to_back;
    int guard;
    int acc2;
    bit got1, got2, drop;
    out_ready = 1'b1;
    key10 = KEY_A;
    ct_in = 8'h38;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    ct_in = 8'h00;
    acc2 = -1; got1 = 0; got2 = 0; drop = 0;
    for (int t = 1; t <= 13; t++) begin
      @(posedge clk); #1;
      if (out_valid && !got1) begin
        got1 = 1;
        checks++;
        if (pt_out !== 8'h97 || t != 4) begin
          failures++;
          $display("FAIL b2b_first: pt=%h t=%0d required 97 at 4", pt_out, t);
        end
      end else if (out_valid && got1 && !got2) begin
        got2 = 1;
        checks++;
        if (pt_out !== 8'hB6 || t != 10) begin
          failures++;
          $display("FAIL b2b_second: pt=%h t=%0d required b6 at 10", pt_out, t);
        end
      end
      if (drop) begin in_valid = 1'b0; drop = 0; end
      if (in_ready && in_valid) begin acc2 = t + 1; drop = 1; end
    end
    in_valid = 1'b0;
    checks++;
    if (acc2 != 6) begin failures++; $display("FAIL b2b_accept_gap: got %0d required 6", acc2); end
    checks++;
    if (!(got1 && got2)) begin failures++; $display("FAIL b2b_count: outputs %0d required 2", int'(got1) + int'(got2)); end
    $display("test_back_to_back: accept gap=%0d", acc2);
  endtask

  task automatic test_reset_mid_op;
    int lat;
    int outs;
    out_ready = 1'b1;
    accept(KEY_A, 8'b00111000);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_in_ready: got %0b required 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) outs++;
    end
    checks++;
    if (outs != 0) begin failures++; $display("FAIL mid_reset_no_output: valid cycles %0d required 0", outs); end
    checks++;
    if (pt_out !== 8'h00) begin failures++; $display("FAIL mid_reset_pt: got %h required 00", pt_out); end
    accept(KEY_A, 8'h00);
    wait_valid(lat);
    checks++;
    if (lat != 4 || pt_out !== 8'hB6) begin
      failures++;
      $display("FAIL mid_reset_recover: pt=%h latency=%0d required b6 at 4", pt_out, lat);
    end
    @(posedge clk); #1;
    $display("test_reset_mid_op: recovered pt=%h latency=%0d", pt_out, lat);
  endtask

  task automatic test_round_trip;
    logic [9:0] key;
    logic [7:0] ct;
    int lat;
    int bad;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      key = (k == 0) ? KEY_A : 10'($urandom);
      bad = 0;
      for (int p = 0; p < 256; p++) begin
        ct = model_encrypt(key, 8'(p));
        accept(key, ct);
        wait_valid(lat);
        checks++;
        if (pt_out !== 8'(p)) begin
          failures++;
          bad++;
          $display("FAIL round_trip: key=%b ct=%h got %h required %h", key, ct, pt_out, 8'(p));
        end
        @(posedge clk); #1;
      end
      $display("test_round_trip: key=%b 256 blocks, %0d wrong", key, bad);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    key10 = '0;
    ct_in = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_known_vector();
    test_backpressure();
    test_input_isolation();
    test_back_to_back();
    test_reset_mid_op();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
